// File: rtl/mem_arbiter.sv
// Two-port request arbiter/sequencer in front of a single-port 1-cycle-latency RAM.
// Optional `MEM_ARB_ROUND_ROBIN_EN selects round-robin tie-breaking; default is fixed priority (port 0).
module mem_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 69
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              req0_valid,
    input  logic              req0_wren,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_data,

    input  logic              req1_valid,
    input  logic              req1_wren,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_data,

    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q,

    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic port_q;
    logic grant0, grant1;
    logic accept;
    logic winner;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // prio_q names the port that wins the next tie: the one not granted last.
    logic prio_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            prio_q <= 1'b0;
        end else if (accept) begin
            prio_q <= ~winner;
        end
    end

    always_comb begin
        grant0 = req0_valid & (~req1_valid | ~prio_q);
        grant1 = req1_valid & (~req0_valid |  prio_q);
    end
`else
    always_comb begin
        grant0 = req0_valid;
        grant1 = req1_valid & ~req0_valid;
    end
`endif

    always_comb begin
        req0_ready = (state_q == IDLE) & grant0;
        req1_ready = (state_q == IDLE) & grant1;
        accept     = req0_ready | req1_ready;
        winner     = req1_ready;
        busy       = (state_q != IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = ISSUE;
            ISSUE:   state_d = ram_wren ? IDLE : CAPTURE;
            CAPTURE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ram_wren is only ever set on the accept edge, so it is high exactly for the ISSUE cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            port_q      <= 1'b0;
            ram_wren    <= 1'b0;
            ram_address <= '0;
            ram_data    <= '0;
            rsp0_valid  <= 1'b0;
            rsp1_valid  <= 1'b0;
            rsp0_data   <= '0;
            rsp1_data   <= '0;
        end else begin
            ram_wren   <= 1'b0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            if (accept) begin
                port_q      <= winner;
                ram_wren    <= winner ? req1_wren : req0_wren;
                ram_address <= winner ? req1_addr : req0_addr;
                ram_data    <= winner ? req1_data : req0_data;
            end
            if (state_q == CAPTURE) begin
                if (port_q) begin
                    rsp1_valid <= 1'b1;
                    rsp1_data  <= ram_q;
                end else begin
                    rsp0_valid <= 1'b1;
                    rsp0_data  <= ram_q;
                end
            end
        end
    end

endmodule
